// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage floating-point rounding pipeline with valid/ready handshake.
// Define FP_ROUND_RMM_EN to enable mode 4 (round to nearest, ties away); otherwise mode 4 rounds as RNE.
module fp_round_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    input  logic [FRAC_WIDTH+2:0] in_frac,
    input  logic [2:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [FRAC_WIDTH-1:0] out_frac,
    output logic                  out_inexact,
    output logic                  out_overflow
);
    localparam logic [EXP_WIDTH-1:0] EMAX  = '1;
    localparam logic [EXP_WIDTH-1:0] EMAX1 = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic                  s1_sign_q, s1_rnd_q, s1_grs_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;
    logic [FRAC_WIDTH-1:0] s1_frac_q;
    logic                  s2_sign_q, s2_inex_q, s2_ovf_q;
    logic [EXP_WIDTH-1:0]  s2_exp_q;
    logic [FRAC_WIDTH-1:0] s2_frac_q;
    logic                  accept, s2_adv, g, r, s, l, any, rmm, rnd, hidden;
    logic [FRAC_WIDTH+1:0] sum;
    logic [EXP_WIDTH-1:0]  res_exp;
    logic [FRAC_WIDTH-1:0] res_frac;
    logic                  res_inex, res_ovf;
    assign in_ready = !s1_valid_q | !s2_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign s2_adv   = s1_valid_q & (!s2_valid_q | out_ready);
    assign s1_valid_d = accept | (s1_valid_q & !s2_adv);
    assign s2_valid_d = s2_adv | (s2_valid_q & !out_ready);
    assign {l, g, r, s} = in_frac[3:0];
    assign any = g | r | s;
`ifdef FP_ROUND_RMM_EN
    assign rmm = in_mode == 3'd4;
`else
    assign rmm = 1'b0;
`endif
    // Reserved mode codes fall through to the RNE term.
    assign rnd = in_mode == 3'd1 ? 1'b0 :
                 in_mode == 3'd2 ? in_sign & any :
                 in_mode == 3'd3 ? !in_sign & any :
                 rmm             ? g : g & (l | r | s);
    assign hidden = |s1_exp_q;
    assign sum    = {1'b0, hidden, s1_frac_q} + (FRAC_WIDTH+2)'(s1_rnd_q);
    always_comb begin
        res_exp  = s1_exp_q;
        res_frac = sum[FRAC_WIDTH-1:0];
        res_inex = s1_grs_q;
        res_ovf  = 1'b0;
        if (s1_exp_q == EMAX) begin
            res_frac = s1_frac_q;
            res_inex = 1'b0;
        end else if (hidden && sum[FRAC_WIDTH+1]) begin
            res_exp  = s1_exp_q + 1'b1;
            res_frac = sum[FRAC_WIDTH:1];
            if (s1_exp_q == EMAX1) begin
                res_frac = '0;
                res_ovf  = 1'b1;
                res_inex = 1'b1;
            end
        end else if (!hidden && sum[FRAC_WIDTH]) begin
            res_exp = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_rnd_q   <= 1'b0;
            s1_grs_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_inex_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_sign_q <= in_sign;
                s1_exp_q  <= in_exp;
                s1_frac_q <= in_frac[FRAC_WIDTH+2:3];
                s1_rnd_q  <= rnd;
                s1_grs_q  <= any;
            end
            if (s2_adv) begin
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= res_exp;
                s2_frac_q <= res_frac;
                s2_inex_q <= res_inex;
                s2_ovf_q  <= res_ovf;
            end
        end
    end
    assign out_valid    = s2_valid_q;
    assign out_sign     = s2_sign_q;
    assign out_exp      = s2_exp_q;
    assign out_frac     = s2_frac_q;
    assign out_inexact  = s2_inex_q;
    assign out_overflow = s2_ovf_q;
endmodule

// File: doc/fp_round_pipe.md
FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, meaning biased exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23, meaning stored fraction width, hidden bit excluded.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: input operand present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the input this cycle.
REQ-007 SHALL have port in_sign, input, 1 bit: operand sign.
REQ-008 SHALL have port in_exp, input, EXP_WIDTH bits: biased exponent; 0 denotes denormal.
REQ-009 SHALL have port in_frac, input, FRAC_WIDTH+3 bits: fraction with guard, round and sticky bits at [2], [1] and [0].
REQ-010 SHALL have port in_mode, input, 3 bits: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 reserved.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake.
REQ-012 SHALL have ports out_sign (1 bit), out_exp (EXP_WIDTH bits) and out_frac (FRAC_WIDTH bits), all outputs: the rounded result.
REQ-013 SHALL have ports out_inexact and out_overflow, outputs, 1 bit each: exception flags for the result.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 registers the operand and the round_up decision, S2 registers the result; latency is 2 cycles with no stall.
REQ-015 SHALL accept a transfer when in_valid and in_ready are both high; an output transfer completes when out_valid and out_ready are both high.
REQ-016 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready; S1 advances only when S2 is empty or S2 is draining this cycle.
REQ-017 SHALL sustain 1 result per cycle while out_ready is high; holds 2 results maximum.
REQ-018 SHALL hold all out_* signals stable while out_valid is high and out_ready is low.
REQ-019 SHALL compute round_up per mode as follows:
- RNE: G & (L | R | S), where L = in_frac[3];
- RTZ: 0;
- RDN: sign & (G | R | S);
- RUP: !sign & (G | R | S);
- RMM: G;
- reserved codes: treated as RNE.
REQ-020 SHALL form the sum as {hidden, frac} + round_up, with hidden = (in_exp != 0); a carry out of a normal operand shifts the fraction right by 1 and adds 1 to the exponent.
REQ-021 SHALL handle a denormal whose increment reaches the hidden position by setting out_exp = 1 and out_frac = 0.
REQ-022 SHALL set out_inexact = G | R | S whenever in_exp != all-ones.
REQ-023 SHALL handle a rounding carry that makes the exponent all-ones as overflow: out_exp = all-ones, out_frac = 0, out_overflow = 1, out_inexact = 1.
REQ-024 SHALL pass in_exp = all-ones (Inf/NaN) through unrounded: in_frac[FRAC_WIDTH+2:3] to out_frac, and both flags 0.
REQ-025 SHALL capture simultaneous input accept and output drain in the same cycle without loss or duplication.

Reset
REQ-026 SHALL, on rst_n low, immediately clear s1_valid, s2_valid and out_valid, independent of clk.
REQ-027 SHALL hold all out_* data and flag outputs at 0 during reset.
REQ-028 SHALL hold in_ready at 1 after reset release.
REQ-029 SHALL discard in-flight operands when reset asserts mid-operation; no output follows reset release until a new input is accepted.

Configuration
REQ-030 SHALL, with macro FP_ROUND_RMM_EN defined, support mode 4 as RMM per REQ-019.
REQ-031 SHALL, with FP_ROUND_RMM_EN undefined, treat mode 4 as reserved (RNE) and synthesize no RMM logic.

Verification
REQ-032 SHALL cover: exp 8'h7F, frac 26'h3FFFFFC, RNE -> 2 cycles later exp 8'h80, frac 0, inexact 1, overflow 0.
REQ-033 SHALL cover: exp 8'h7F, frac 26'h0000004, RNE -> frac 0, inexact 1; with FP_ROUND_RMM_EN, RMM -> frac 23'h000001.
REQ-034 SHALL cover: exp 8'hFE, frac 26'h3FFFFFC, sign 0:
- RUP -> exp 8'hFF, frac 0, overflow 1;
- RTZ -> exp 8'hFE, frac 23'h7FFFFF, overflow 0.
REQ-035 SHALL cover: exp 0, frac 26'h3FFFFFC, RNE -> exp 1, frac 0, inexact 1; exp 8'hFF, frac 26'h0000007 -> frac 0, flags 0.
REQ-036 SHALL cover: out_ready low, 3 back-to-back inputs -> in_ready low after 2 accepted, outputs stable; out_ready high -> 3 results in order, 1 per cycle.
REQ-037 SHALL cover: rst_n pulsed low with 2 results in flight -> out_valid 0 within the same cycle, no stale result after release.
